// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester round-robin arbiter/sequencer for the shared ALU.
//            Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  op0,
  input  logic [2:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result,
  output logic        zero,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_owner;
  logic   w_accept;
  logic   w_winner;

  assign w_accept = (r_state == ST_IDLE) && (req0 || req1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_winner = ~req0;
`else
  logic r_last;

  // On a tie the requester that did not win last time takes the ALU.
  assign w_winner = (req0 && req1) ? ~r_last : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_winner;
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    done0        = 1'b0;
    done1        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        gnt0         = ~r_owner;
        gnt1         = r_owner;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        done0        = ~r_owner;
        done1        = r_owner;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      alu_op  <= 3'd0;
      alu_a   <= 32'd0;
      alu_b   <= 32'd0;
      result  <= 32'd0;
      zero    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // ALU operand registers only move on acceptance so the ALU sees stable inputs.
      if (w_accept) begin
        r_owner <= w_winner;
        alu_op  <= w_winner ? op1 : op0;
        alu_a   <= w_winner ? a1  : a0;
        alu_b   <= w_winner ? b1  : b0;
      end
      if (r_state == ST_EXEC) begin
        result <= alu_result;
        zero   <= alu_zero;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed and randomized self-checking bench for alu_arbiter,
//            including an ALU model and a transaction-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [2:0]  op0 = 3'd0, op1 = 3'd0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic        gnt0, gnt1, done0, done1, zero, alu_zero;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOR:  return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Scheduler model: an acceptance at edge E books the ALU until edge E+3.
  int          edge_n = 0;
  int          acc_edge = -10;
  int          free_edge = 0;
  bit          pend = 1'b0;
  bit          own = 1'b0;
  bit          last_m = 1'b1;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
  logic        m_zero = 1'b0;

  task automatic model_edge();
    bit w;
    edge_n++;
    if (rst) begin
      pend = 1'b0; last_m = 1'b1; free_edge = edge_n + 1;
      m_op = 3'd0; m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_zero = 1'b0;
    end else begin
      if (pend && edge_n == acc_edge + 1) begin
        m_res  = alu_f(m_op, m_a, m_b);
        m_zero = (m_res == 32'd0);
      end
      if (edge_n >= free_edge && (req0 || req1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = !req0;
`else
        w = (req0 && req1) ? !last_m : !req0;
`endif
        pend = 1'b1; own = w; acc_edge = edge_n; free_edge = edge_n + 3; last_m = w;
        m_op = w ? op1 : op0;
        m_a  = w ? a1 : a0;
        m_b  = w ? b1 : b0;
      end
    end
  endtask

  function automatic bit exp_gnt(input bit who);
    return pend && edge_n == acc_edge && own == who;
  endfunction

  function automatic bit exp_done(input bit who);
    return pend && edge_n == acc_edge + 1 && own == who;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("gnt0",   32'(gnt0),  32'(exp_gnt(1'b0)));
    chk("gnt1",   32'(gnt1),  32'(exp_gnt(1'b1)));
    chk("done0",  32'(done0), 32'(exp_done(1'b0)));
    chk("done1",  32'(done1), 32'(exp_done(1'b1)));
    chk("result", result,     m_res);
    chk("zero",   32'(zero),  32'(m_zero));
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("alu_a",  alu_a,      m_a);
    chk("alu_b",  alu_b,      m_b);
  endtask

  task automatic rand_ops(output logic [2:0] op, output logic [31:0] a, output logic [31:0] b);
    logic [2:0] ops [5] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR};
    op = ops[$urandom_range(0, 4)];
    a  = $urandom;
    b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  task automatic rand_drive();
    rst = ($urandom_range(0, 59) == 0);
    if (exp_gnt(1'b0)) begin
      req0 = 1'($urandom_range(0, 1));
      if (req0) rand_ops(op0, a0, b0);
    end else if (!req0) begin
      if ($urandom_range(0, 3) == 0) begin req0 = 1'b1; rand_ops(op0, a0, b0); end
    end else if (edge_n + 1 >= free_edge && $urandom_range(0, 19) == 0) begin
      req0 = 1'b0;
    end
    if (exp_gnt(1'b1)) begin
      req1 = 1'($urandom_range(0, 1));
      if (req1) rand_ops(op1, a1, b1);
    end else if (!req1) begin
      if ($urandom_range(0, 3) == 0) begin req1 = 1'b1; rand_ops(op1, a1, b1); end
    end else if (edge_n + 1 >= free_edge && $urandom_range(0, 19) == 0) begin
      req1 = 1'b0;
    end
  endtask

  int gseq[$];
  int gcyc[$];

  initial begin
    // Reset and idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_pulses", 32'({gnt0, gnt1, done0, done1}), 32'd0);
    end

    // Single NOR request
    req0 = 1'b1; op0 = OP_NOR; a0 = 32'h0000_00FF; b0 = 32'h0000_0F00;
    step();
    chk("nor_gnt0", 32'(gnt0), 32'd1);
    chk("nor_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0;
    step();
    chk("nor_done0",  32'(done0), 32'd1);
    chk("nor_done1",  32'(done1), 32'd0);
    chk("nor_result", result, 32'hFFFF_F000);
    chk("nor_zero",   32'(zero), 32'd0);
    step();

    // Zero flag via SUB
    req1 = 1'b1; op1 = OP_SUB; a1 = 32'h1234_5678; b1 = 32'h1234_5678;
    step();
    chk("sub_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step();
    chk("sub_done1",  32'(done1), 32'd1);
    chk("sub_result", result, 32'd0);
    chk("sub_zero",   32'(zero), 32'd1);
    step();

    // Late request arriving during DONE
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7;
    step();
    req0 = 1'b0;
    step();
    chk("late_done0", 32'(done0), 32'd1);
    req1 = 1'b1; op1 = OP_OR; a1 = 32'h0000_F000; b1 = 32'h0000_000F;
    step();
    chk("late_nognt", 32'(gnt1), 32'd0);
    step();
    chk("late_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    step(); step();

    // Continuous tie from reset release
    rst = 1'b1;
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1;    b0 = 32'd2;
    req1 = 1'b1; op1 = OP_OR;  a1 = 32'h10;  b1 = 32'h01;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (gnt0) begin gseq.push_back(0); gcyc.push_back(edge_n); end
      if (gnt1) begin gseq.push_back(1); gcyc.push_back(edge_n); end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_count", 32'(gseq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gseq.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("tie_seq", 32'(gseq[i]), 32'd0);
`else
      chk("tie_seq", 32'(gseq[i]), 32'(i % 2));
`endif
      if (i > 0) chk("tie_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end
    step(); step();

    // Reset during EXEC aborts the op and restores req0 tie priority
    req0 = 1'b1; op0 = OP_AND; a0 = 32'h0000_FFFF; b0 = 32'h0000_0F0F;
    step();
    chk("mid_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_nodone", 32'(done0), 32'd0);
    chk("mid_result", result, 32'd0);
    step();
    chk("mid_nodone2", 32'(done0), 32'd0);
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("mid_tie_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rand_drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU datapath (AND/OR/NOR/ADD/SUB slices). It accepts operation requests from two masters, grants the ALU in round-robin order, and registers the operands into the ALU. It then captures the combinational ALU result and returns it with a one-cycle done pulse to the winning requester. It sits between the control unit / multi-cycle datapath masters and the ALU-32Bit instance.

## Interface
- No parameters; data width fixed at 32, op width fixed at 3.
- Clock is `clk`, single clock domain, rising edge. Reset is `rst`, synchronous, active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req0`, `req1`  in  1 each  request; held high until the matching grant.
- `op0`, `op1`  in  3 each  ALU op code; passed to the ALU unmodified.
- `a0`, `b0`, `a1`, `b1`  in  32 each  operands.
- `gnt0`, `gnt1`  out  1 each  one-cycle pulse acknowledging acceptance.
- `done0`, `done1`  out  1 each  one-cycle pulse; `result` and `zero` are valid.
- `result`  out  32  registered ALU result.
- `zero`  out  1  registered ALU zero flag.
- `alu_op`  out  3  to the ALU.
- `alu_a`, `alu_b`  out  32 each  to the ALU.
- `alu_result`  in  32  from the ALU, combinational.
- `alu_zero`  in  1  from the ALU, combinational.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE:** if `req0` or `req1` is high at a clock edge:
  - Select the winner.
  - Latch its op and operands into `alu_op`/`alu_a`/`alu_b`.
  - Record the owner.
  - Go to EXEC.
  - If neither request is high, stay in IDLE.
- **EXEC:** raise `gnt<owner>` for this cycle. The ALU evaluates the latched operands. At the edge, capture `alu_result`→`result` and `alu_zero`→`zero`, then go to DONE.
- **DONE:** raise `done<owner>` for this cycle, then go to IDLE unconditionally.
- **Round-robin:**
  - `last` pointer records the last owner.
  - When both requests are high, the requester that is not `last` wins.
  - With a single request, that requester wins regardless of `last`.
  - `last` updates on acceptance.
- A requester deasserting before its grant withdraws the request. This is legal only in IDLE and has no side effect.
- Requests are ignored in EXEC and DONE; a request held across DONE is evaluated in the following IDLE cycle.
- `alu_op`/`alu_a`/`alu_b` hold their value outside acceptance edges, so no operand glitches reach the ALU.
- `result`/`zero` hold their value until the next capture.

## Timing
- Reset values: state IDLE, `last`=1 (so `req0` wins the first tie), all gnt/done pulses 0, `result`=0, `zero`=0, `alu_op`=0, `alu_a`=0, `alu_b`=0.
- Request accepted at edge N:
  - `gnt` high in cycle N+1.
  - `result` valid and `done` high in cycle N+2.
  - Earliest next acceptance at the edge ending cycle N+3, i.e. the IDLE cycle.
- Throughput: one operation per 3 cycles. Under continuous contention the two requesters strictly alternate.
- At most one of `gnt0`/`gnt1`/`done0`/`done1` is high in any cycle.
- `rst` asserted in EXEC or DONE:
  - Next state is IDLE.
  - No `done` pulse is issued for the aborted op.
  - `result` is cleared.
  - `last` returns to 1.
- `rst` has priority over every transition.

## Configuration
- Macro `ALU_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority; `req0` always wins ties, and the `last` pointer is not implemented.
- **Undefined (default):** round-robin as described above.
- Latency and handshake timing are identical in both builds.

## Test plan
- **Reset:** hold `rst` 2 cycles, release. Required: all outputs 0, state IDLE, no pulses for 5 idle cycles.
- **Single NOR request:** `req0` with `a0`=0x0000_00FF, `b0`=0x0000_0F00, op=NOR.
  - `gnt0` in cycle N+1.
  - `done0` in N+2 with `result`=0xFFFF_F000, `zero`=0.
  - `gnt1`/`done1` never assert.
- **Tie:** `req0` and `req1` both high from reset release, held continuously.
  - Grant sequence is 0,1,0,1, with grants 3 cycles apart.
  - Under `ALU_ARB_FIXED_PRIO_EN` the sequence is 0,0,0,0.
- **Zero flag:** `req1` with SUB, `a1`=`b1`=0x1234_5678. Required: `done1` with `result`=0x0000_0000, `zero`=1.
- **Reset mid-op:** accept `req0`, assert `rst` during EXEC. Required: no `done0`, `result`=0, and the next tie is won by `req0`.
- **Late request:** `req1` rises during DONE of a `req0` op. Required: accepted at the following IDLE edge, `gnt1` exactly 2 cycles after that DONE cycle.
